// File: rtl/multi_glitch_filter.sv
`default_nettype none
// =============================================================================
// Module   : multi_glitch_filter
// Purpose  : Multi-channel synchroniser + stability-counter glitch filter with
//            per-channel edge strobes and sticky glitch flags.
// Revision : 1.0
// =============================================================================
module multi_glitch_filter #(
    parameter int                  CHANNELS    = 4,
    parameter int                  MIN_PULSE   = 4,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [CHANNELS-1:0] RESET_VALUE = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                glitch_clr,
    input  logic [CHANNELS-1:0] signal_in,
    output logic [CHANNELS-1:0] signal_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] glitch_seen
);

    localparam int                 c_cnt_w = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(MIN_PULSE - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] w_next_out;
    logic [CHANNELS-1:0] w_glitch_set;
    logic [CHANNELS-1:0] r_out;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic [CHANNELS-1:0] r_glitch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= RESET_VALUE;
            end
        end else begin
            r_sync[0] <= signal_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [c_cnt_w-1:0] r_cnt;
            logic [c_cnt_w-1:0] w_cnt_nxt;
            logic               w_out_nxt;
            logic               w_set;

            // Bypass forces the count to zero so re-enabling starts a fresh qualification.
            always_comb begin
                w_out_nxt = r_out[i];
                w_cnt_nxt = '0;
                w_set     = 1'b0;
                if (!enable) begin
                    w_out_nxt = w_s[i];
                end else if (w_s[i] == r_out[i]) begin
                    w_set = (r_cnt != '0);
                end else if (r_cnt == c_last) begin
                    w_out_nxt = w_s[i];
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_nxt;
                end
            end

            assign w_next_out[i]   = w_out_nxt;
            assign w_glitch_set[i] = w_set;
        end
    endgenerate

    // Strobes are derived from the next value so they line up with the new level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out    <= RESET_VALUE;
            r_rise   <= '0;
            r_fall   <= '0;
            r_glitch <= '0;
        end else begin
            r_out    <= w_next_out;
            r_rise   <= w_next_out & ~r_out;
            r_fall   <= ~w_next_out & r_out;
            r_glitch <= (r_glitch & ~{CHANNELS{glitch_clr}}) | w_glitch_set;
        end
    end

    assign signal_out  = r_out;
    assign rise_pulse  = r_rise;
    assign fall_pulse  = r_fall;
    assign glitch_seen = r_glitch;

endmodule
`default_nettype wire

// File: tb/tb_multi_glitch_filter.sv
`default_nettype none
// =============================================================================
// Module   : tb_multi_glitch_filter
// Purpose  : Directed self-checking bench for multi_glitch_filter (4 ch, MIN_PULSE=4).
// Revision : 1.0
// =============================================================================
module tb_multi_glitch_filter;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       glitch_clr;
    logic [3:0] signal_in;
    logic [3:0] signal_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic [3:0] glitch_seen;
    int         checks;
    int         failures;

    multi_glitch_filter #(
        .CHANNELS    (4),
        .MIN_PULSE   (4),
        .SYNC_STAGES (2),
        .RESET_VALUE (4'b0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .glitch_clr  (glitch_clr),
        .signal_in   (signal_in),
        .signal_out  (signal_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .glitch_seen (glitch_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1ns past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; glitch_clr = 1'b0; signal_in = 4'h0;
        tick(2);
        rst = 1'b0; signal_in = 4'hF;
        tick(8);
        checks++; if (signal_out !== 4'hF) begin failures++; $display("FAIL prefill_out: got %h expected %h", signal_out, 4'hF); end
        #3 rst = 1'b1;
        #1;
        checks++; if (signal_out !== 4'h0) begin failures++; $display("FAIL rst_async_out: got %h expected %h", signal_out, 4'h0); end
        checks++; if ({rise_pulse, fall_pulse, glitch_seen} !== 12'h000) begin failures++; $display("FAIL rst_async_flags: got %h expected %h", {rise_pulse, fall_pulse, glitch_seen}, 12'h000); end
        tick(1);
        rst = 1'b0;
        tick(5);
        checks++; if (signal_out !== 4'h0) begin failures++; $display("FAIL rst_rel_early: got %h expected %h", signal_out, 4'h0); end
        tick(1);
        checks++; if (signal_out !== 4'hF) begin failures++; $display("FAIL rst_rel_out: got %h expected %h", signal_out, 4'hF); end
        checks++; if (rise_pulse !== 4'hF) begin failures++; $display("FAIL rst_rel_rise: got %h expected %h", rise_pulse, 4'hF); end
        tick(1);
        checks++; if (rise_pulse !== 4'h0) begin failures++; $display("FAIL rst_rel_rise_end: got %h expected %h", rise_pulse, 4'h0); end
    endtask

    task automatic test_glitch();
        logic any_rise;
        logic any_out;
        signal_in = 4'h0;
        tick(8);
        checks++; if ({signal_out, glitch_seen} !== 8'h00) begin failures++; $display("FAIL gl_base: got %h expected %h", {signal_out, glitch_seen}, 8'h00); end
        any_rise = 1'b0; any_out = 1'b0;
        signal_in = 4'h1;
        for (int n = 0; n < 3; n++) begin
            tick(1);
            any_rise = any_rise | rise_pulse[0];
            any_out  = any_out | signal_out[0];
        end
        signal_in = 4'h0;
        for (int n = 0; n < 8; n++) begin
            tick(1);
            any_rise = any_rise | rise_pulse[0];
            any_out  = any_out | signal_out[0];
        end
        checks++; if (any_out !== 1'b0) begin failures++; $display("FAIL gl_out_leak: got %b expected %b", any_out, 1'b0); end
        checks++; if (any_rise !== 1'b0) begin failures++; $display("FAIL gl_rise_leak: got %b expected %b", any_rise, 1'b0); end
        checks++; if (glitch_seen !== 4'h1) begin failures++; $display("FAIL gl_seen: got %h expected %h", glitch_seen, 4'h1); end
        tick(3);
        checks++; if (glitch_seen !== 4'h1) begin failures++; $display("FAIL gl_sticky: got %h expected %h", glitch_seen, 4'h1); end
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        checks++; if (glitch_seen !== 4'h0) begin failures++; $display("FAIL gl_clr: got %h expected %h", glitch_seen, 4'h0); end
    endtask

    task automatic test_accept();
        signal_in = 4'h2;
        tick(5);
        checks++; if (signal_out !== 4'h0) begin failures++; $display("FAIL acc_early: got %h expected %h", signal_out, 4'h0); end
        tick(1);
        checks++; if (signal_out !== 4'h2) begin failures++; $display("FAIL acc_out: got %h expected %h", signal_out, 4'h2); end
        checks++; if (rise_pulse !== 4'h2) begin failures++; $display("FAIL acc_rise: got %h expected %h", rise_pulse, 4'h2); end
        tick(1);
        checks++; if (rise_pulse !== 4'h0) begin failures++; $display("FAIL acc_rise_end: got %h expected %h", rise_pulse, 4'h0); end
        tick(4);
        signal_in = 4'h0;
        tick(5);
        checks++; if ({signal_out, fall_pulse} !== 8'h20) begin failures++; $display("FAIL acc_fall_early: got %h expected %h", {signal_out, fall_pulse}, 8'h20); end
        tick(1);
        checks++; if (signal_out !== 4'h0) begin failures++; $display("FAIL acc_fall_out: got %h expected %h", signal_out, 4'h0); end
        checks++; if ({rise_pulse, fall_pulse} !== 8'h02) begin failures++; $display("FAIL acc_fall_pulse: got %h expected %h", {rise_pulse, fall_pulse}, 8'h02); end
        tick(1);
        checks++; if ({fall_pulse, glitch_seen} !== 8'h00) begin failures++; $display("FAIL acc_fall_end: got %h expected %h", {fall_pulse, glitch_seen}, 8'h00); end
    endtask

    task automatic test_independence();
        signal_in = 4'hC;
        tick(2);
        signal_in = 4'h8;
        tick(2);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        checks++; if (glitch_seen !== 4'h4) begin failures++; $display("FAIL ind_set_vs_clr: got %h expected %h", glitch_seen, 4'h4); end
        checks++; if ({signal_out, rise_pulse} !== 8'h00) begin failures++; $display("FAIL ind_early: got %h expected %h", {signal_out, rise_pulse}, 8'h00); end
        tick(1);
        checks++; if ({signal_out, rise_pulse} !== 8'h88) begin failures++; $display("FAIL ind_ch3_rise: got %h expected %h", {signal_out, rise_pulse}, 8'h88); end
        checks++; if (glitch_seen !== 4'h4) begin failures++; $display("FAIL ind_glitch: got %h expected %h", glitch_seen, 4'h4); end
        signal_in = 4'h0;
        tick(8);
        checks++; if (signal_out !== 4'h0) begin failures++; $display("FAIL ind_cleanup: got %h expected %h", signal_out, 4'h0); end
    endtask

    task automatic test_bypass();
        enable = 1'b0;
        tick(2);
        signal_in = 4'h1;
        tick(1);
        signal_in = 4'h0;
        tick(1);
        checks++; if (signal_out !== 4'h0) begin failures++; $display("FAIL byp_early: got %h expected %h", signal_out, 4'h0); end
        tick(1);
        checks++; if ({signal_out, rise_pulse, fall_pulse} !== 12'h110) begin failures++; $display("FAIL byp_rise: got %h expected %h", {signal_out, rise_pulse, fall_pulse}, 12'h110); end
        tick(1);
        checks++; if ({signal_out, rise_pulse, fall_pulse} !== 12'h001) begin failures++; $display("FAIL byp_fall: got %h expected %h", {signal_out, rise_pulse, fall_pulse}, 12'h001); end
        checks++; if (glitch_seen !== 4'h4) begin failures++; $display("FAIL byp_glitch_hold: got %h expected %h", glitch_seen, 4'h4); end
        tick(1);
        signal_in = 4'h1;
        tick(2);
        enable = 1'b1;
        tick(3);
        checks++; if (signal_out !== 4'h0) begin failures++; $display("FAIL byp_reen_early: got %h expected %h", signal_out, 4'h0); end
        tick(1);
        checks++; if ({signal_out, rise_pulse} !== 8'h11) begin failures++; $display("FAIL byp_reen_rise: got %h expected %h", {signal_out, rise_pulse}, 8'h11); end
        checks++; if (glitch_seen !== 4'h4) begin failures++; $display("FAIL byp_reen_glitch: got %h expected %h", glitch_seen, 4'h4); end
    endtask

    task automatic test_reset_midcount();
        tick(1);
        signal_in = 4'h5;
        tick(4);
        #3 rst = 1'b1;
        #1;
        checks++; if ({signal_out, glitch_seen} !== 8'h00) begin failures++; $display("FAIL mid_rst_clear: got %h expected %h", {signal_out, glitch_seen}, 8'h00); end
        tick(1);
        rst = 1'b0;
        tick(5);
        checks++; if (signal_out !== 4'h0) begin failures++; $display("FAIL mid_rel_early: got %h expected %h", signal_out, 4'h0); end
        tick(1);
        checks++; if ({signal_out, rise_pulse} !== 8'h55) begin failures++; $display("FAIL mid_rel_rise: got %h expected %h", {signal_out, rise_pulse}, 8'h55); end
        checks++; if (glitch_seen !== 4'h0) begin failures++; $display("FAIL mid_rel_glitch: got %h expected %h", glitch_seen, 4'h0); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        enable = 1'b1;
        glitch_clr = 1'b0;
        signal_in = 4'h0;
        test_reset();
        test_glitch();
        test_accept();
        test_independence();
        test_bypass();
        test_reset_midcount();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
